// File: rtl/commu_fx_bridge.sv
// UART byte-stream to fx-bus bridge: parses write/read command frames, issues a
// single fx access, and returns an ack byte or the read data to the transmitter.
module commu_fx_bridge #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int TIMEOUT_US = 1000
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_us,
  input  logic [7:0]        rx_data,
  input  logic              rx_vld,
  output logic [7:0]        tx_data,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic [ADDR_W-1:0] fx_waddr,
  output logic              fx_wr,
  output logic [DATA_W-1:0] fx_data,
  output logic              fx_rd,
  output logic [ADDR_W-1:0] fx_raddr,
  input  logic [DATA_W-1:0] fx_q,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  // state  | meaning
  // IDLE   | waiting for a command byte
  // ADDR   | shifting in address bytes, MSB first
  // DATA   | shifting in write-data bytes, MSB first
  // WR     | one-cycle fx write strobe, ack byte loaded
  // RD     | one-cycle fx read strobe
  // RDWAIT | waiting RD_LAT cycles for fx_q
  // TX     | streaming the response bytes
  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int DATA_BYTES = (DATA_W + 7) / 8;
  localparam int ASH_W      = 8 * ADDR_BYTES;
  localparam int DSH_W      = 8 * DATA_BYTES;
  localparam int TXB_W      = DSH_W + 8;

  localparam logic [7:0]  CMD_WR  = 8'h57;
  localparam logic [7:0]  CMD_RD  = 8'h52;
  localparam logic [7:0]  ACK     = 8'h4B;
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_US);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, RD, RDWAIT, TX} state_t;

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [3:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [ASH_W-1:0]  addr_sh_q, addr_sh_d;
  logic [DSH_W-1:0]  data_sh_q, data_sh_d;
  logic [TXB_W-1:0]  tx_buf_q, tx_buf_d;
  logic [3:0]        tx_left_q, tx_left_d;
  logic [ADDR_W-1:0] fx_waddr_q, fx_waddr_d;
  logic [ADDR_W-1:0] fx_raddr_q, fx_raddr_d;
  logic [DATA_W-1:0] fx_data_q, fx_data_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic [ASH_W-1:0]  addr_next;
  logic [DSH_W-1:0]  data_next;

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    byte_cnt_d  = byte_cnt_q;
    to_cnt_d    = to_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    tx_buf_d    = tx_buf_q;
    tx_left_d   = tx_left_q;
    fx_waddr_d  = fx_waddr_q;
    fx_raddr_d  = fx_raddr_q;
    fx_data_d   = fx_data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    addr_next   = (addr_sh_q << 8) | ASH_W'(rx_data);
    data_next   = (data_sh_q << 8) | DSH_W'(rx_data);

    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            is_wr_d    = (rx_data == CMD_WR);
            byte_cnt_d = 4'(ADDR_BYTES - 1);
            to_cnt_d   = TO_LOAD;
            state_d    = ADDR;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ADDR, DATA: begin
        // An arriving byte always beats a simultaneous timeout tick.
        if (rx_vld) begin
          to_cnt_d   = TO_LOAD;
          byte_cnt_d = byte_cnt_q - 4'd1;
          if (state_q == ADDR) begin
            addr_sh_d = addr_next;
            if (byte_cnt_q == 4'd0) begin
              if (is_wr_q) begin
                byte_cnt_d = 4'(DATA_BYTES - 1);
                state_d    = DATA;
              end else begin
                fx_raddr_d = addr_next[ADDR_W-1:0];
                state_d    = RD;
              end
            end
          end else begin
            data_sh_d = data_next;
            if (byte_cnt_q == 4'd0) begin
              fx_waddr_d = addr_sh_q[ADDR_W-1:0];
              fx_data_d  = data_next[DATA_W-1:0];
              state_d    = WR;
            end
          end
        end else if (pluse_us) begin
          if (to_cnt_q == 16'd1) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            to_cnt_d = to_cnt_q - 16'd1;
          end
        end
      end
      WR: begin
        tx_buf_d  = {ACK, {DSH_W{1'b0}}};
        tx_left_d = 4'd1;
        state_d   = TX;
      end
      RD: begin
        lat_cnt_d = 3'(RD_LAT - 1);
        state_d   = RDWAIT;
      end
      RDWAIT: begin
        if (lat_cnt_q == 3'd0) begin
          tx_buf_d  = {CMD_RD, DSH_W'(fx_q)};
          tx_left_d = 4'(DATA_BYTES + 1);
          state_d   = TX;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      TX: begin
        if (tx_rdy) begin
          if (tx_left_q == 4'd1) begin
            state_d = IDLE;
          end else begin
            tx_buf_d  = tx_buf_q << 8;
            tx_left_d = tx_left_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_vld && (state_q == WR || state_q == RD || state_q == RDWAIT || state_q == TX))
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      tx_buf_q    <= '0;
      tx_left_q   <= '0;
      fx_waddr_q  <= '0;
      fx_raddr_q  <= '0;
      fx_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      tx_buf_q    <= tx_buf_d;
      tx_left_q   <= tx_left_d;
      fx_waddr_q  <= fx_waddr_d;
      fx_raddr_q  <= fx_raddr_d;
      fx_data_q   <= fx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign fx_wr     = (state_q == WR);
  assign fx_rd     = (state_q == RD);
  assign tx_vld    = (state_q == TX);
  assign tx_data   = tx_vld ? tx_buf_q[TXB_W-1 -: 8] : 8'h00;
  assign fx_waddr  = fx_waddr_q;
  assign fx_raddr  = fx_raddr_q;
  assign fx_data   = fx_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_commu_fx_bridge.sv
// Bench for commu_fx_bridge: frame-level reference model compared every cycle,
// directed frames with literal expectations, randomized traffic, narrow-width instance.
module tb_commu_fx_bridge;
  localparam int AB  = 2;
  localparam int DB  = 4;
  localparam int RDL = 2;
  localparam int TO  = 4;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        pluse_us = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic        tx_rdy = 1'b1;
  logic [31:0] fx_q = 32'h0;
  logic [7:0]  tx_data;
  logic        tx_vld, fx_wr, fx_rd, busy, frame_err, overrun;
  logic [15:0] fx_waddr, fx_raddr;
  logic [31:0] fx_data;

  logic [7:0]  rx2_data = 8'h00;
  logic        rx2_vld = 1'b0;
  logic        tx2_rdy = 1'b1;
  logic        pluse2 = 1'b0;
  logic [11:0] fx_q2 = 12'hABC;
  logic [7:0]  tx2_data;
  logic        tx2_vld, fx_wr2, fx_rd2, busy2, ferr2, ovr2;
  logic [9:0]  fx_waddr2, fx_raddr2;
  logic [11:0] fx_data2;

  always #5 clk_sys = ~clk_sys;

  commu_fx_bridge #(.ADDR_W(16), .DATA_W(32), .RD_LAT(RDL), .TIMEOUT_US(TO)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .fx_waddr(fx_waddr), .fx_wr(fx_wr),
    .fx_data(fx_data), .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .busy(busy),
    .frame_err(frame_err), .overrun(overrun));

  commu_fx_bridge #(.ADDR_W(10), .DATA_W(12), .RD_LAT(1), .TIMEOUT_US(4)) dut2 (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse2), .rx_data(rx2_data), .rx_vld(rx2_vld),
    .tx_data(tx2_data), .tx_vld(tx2_vld), .tx_rdy(tx2_rdy), .fx_waddr(fx_waddr2), .fx_wr(fx_wr2),
    .fx_data(fx_data2), .fx_rd(fx_rd2), .fx_raddr(fx_raddr2), .fx_q(fx_q2), .busy(busy2),
    .frame_err(ferr2), .overrun(ovr2));

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 0;
  bit force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  logic [7:0] txlog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  function automatic logic [63:0] pack_log();
    logic [63:0] v = 64'h0;
    foreach (txlog[i]) v = {v[55:0], txlog[i]};
    return v;
  endfunction

  // Frame-level reference model: mode 0 idle, 1 collecting, 2 responding.
  // m_k counts cycles since the last frame byte; the response timeline is
  // strobe at k=1, read capture at k=1+RDL, transmission from k=2 (write) or k=2+RDL (read).
  int m_mode = 0;
  int m_need = 0, m_gap = 0, m_k = 0;
  bit m_wr = 1'b0;
  logic [7:0] m_frame[$];
  logic [7:0] m_resp[$];
  logic [15:0] m_waddr = 16'h0, m_raddr = 16'h0;
  logic [31:0] m_wdata = 32'h0;
  logic e_tx_vld = 1'b0, e_fx_wr = 1'b0, e_fx_rd = 1'b0, e_busy = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0;
  logic [7:0] e_tx_data = 8'h0;

  task automatic model_step();
    logic vld_now;
    longint unsigned a, d;
    vld_now = e_tx_vld;
    e_ferr = 1'b0;
    e_ovr = 1'b0;
    if (rst) begin
      m_mode = 0; m_frame.delete(); m_resp.delete();
      m_waddr = 16'h0; m_raddr = 16'h0; m_wdata = 32'h0;
    end else begin
      case (m_mode)
        0: if (rx_vld) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            m_mode = 1; m_wr = (rx_data == 8'h57); m_frame.delete();
            m_need = AB + (m_wr ? DB : 0); m_gap = 0;
          end else e_ferr = 1'b1;
        end
        1: if (rx_vld) begin
          m_frame.push_back(rx_data); m_gap = 0;
          if (m_frame.size() == m_need) begin
            a = 0; d = 0;
            for (int i = 0; i < AB; i++) a = (a << 8) | longint'(m_frame[i]);
            for (int i = AB; i < m_need; i++) d = (d << 8) | longint'(m_frame[i]);
            m_resp.delete();
            if (m_wr) begin m_waddr = a[15:0]; m_wdata = d[31:0]; m_resp.push_back(8'h4B); end
            else m_raddr = a[15:0];
            m_mode = 2; m_k = 0;
          end
        end else if (pluse_us) begin
          m_gap++;
          if (m_gap == TO) begin e_ferr = 1'b1; m_mode = 0; end
        end
        default: begin
          if (rx_vld) e_ovr = 1'b1;
          if (vld_now && tx_rdy) begin
            void'(m_resp.pop_front());
            if (m_resp.size() == 0) m_mode = 0;
          end
          if (!m_wr && m_k == 1 + RDL) begin
            m_resp.push_back(8'h52);
            for (int i = DB - 1; i >= 0; i--) m_resp.push_back(fx_q[8*i +: 8]);
          end
        end
      endcase
    end
    if (m_mode == 2) m_k++;
    e_busy    = (m_mode != 0);
    e_fx_wr   = (m_mode == 2) && m_wr && (m_k == 1);
    e_fx_rd   = (m_mode == 2) && !m_wr && (m_k == 1);
    e_tx_vld  = (m_mode == 2) && (m_k >= (m_wr ? 2 : 2 + RDL)) && (m_resp.size() > 0);
    e_tx_data = e_tx_vld ? m_resp[0] : 8'h00;
  endtask

  initial forever begin
    @(posedge clk_sys);
    cycle++;
    model_step();
  end

  initial forever begin
    @(negedge clk_sys);
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("tx_vld", tx_vld, e_tx_vld);
      if (e_tx_vld) chk("tx_data", tx_data, e_tx_data);
      chk("fx_wr", fx_wr, e_fx_wr);
      chk("fx_rd", fx_rd, e_fx_rd);
      chk("frame_err", frame_err, e_ferr);
      chk("overrun", overrun, e_ovr);
      chk("fx_waddr", fx_waddr, m_waddr);
      chk("fx_data", fx_data, m_wdata);
      chk("fx_raddr", fx_raddr, m_raddr);
    end
    if (tx_vld && tx_rdy) txlog.push_back(tx_data);
  end

  logic [7:0] rd_hist = 8'h0;
  initial forever begin
    @(negedge clk_sys);
    rd_hist = {rd_hist[6:0], fx_rd};
    if (rd_hist[RDL] && force_en) fx_q = force_val;
    else fx_q = $urandom;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_sys); #1;
    rx_vld = 1'b0;
    pluse_us = 1'b0;
    case (rdy_mode)
      0: tx_rdy = 1'b1;
      1: tx_rdy = 1'($urandom_range(0, 1));
      default: tx_rdy = 1'b0;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    rx_vld = 1'b1; rx_data = b; cyc();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin cyc(); n++; end
    chk(nm, busy, 1'b0);
  endtask

  task automatic send2(input logic [7:0] b);
    rx2_vld = 1'b1; rx2_data = b;
    @(posedge clk_sys); #1;
    rx2_vld = 1'b0;
  endtask

  int pend[$];
  task automatic build_frame();
    int kind;
    int b;
    kind = $urandom_range(0, 9);
    if (kind < 4) begin
      pend.push_back(8'h57);
      repeat (AB + DB) pend.push_back(int'($urandom_range(0, 255)));
    end else if (kind < 8) begin
      pend.push_back(8'h52);
      repeat (AB) pend.push_back(int'($urandom_range(0, 255)));
    end else if (kind == 8) begin
      do b = int'($urandom_range(0, 255)); while (b == 8'h57 || b == 8'h52);
      pend.push_back(b);
    end else begin
      pend.push_back($urandom_range(0, 1) ? 8'h57 : 8'h52);
      pend.push_back(int'($urandom_range(0, 255)));
      repeat (6) pend.push_back(-1);
    end
  endtask

  initial begin
    logic [7:0] got2[$];
    int v;
    // reset
    rst = 1'b1;
    cyc(); cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_tx_vld", tx_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fx_waddr", fx_waddr, 16'h0);
    chk("rst_fx_data", fx_data, 32'h0);
    cyc();

    // write frame
    txlog.delete(); rdy_mode = 0;
    send(8'h57); send(8'h12); send(8'h34); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("wr_strobe", fx_wr, 1'b1);
    chk("wr_addr", fx_waddr, 16'h1234);
    chk("wr_data", fx_data, 32'hDEADBEEF);
    cyc();
    chk("wr_strobe_gone", fx_wr, 1'b0);
    chk("wr_ack_vld", tx_vld, 1'b1);
    chk("wr_ack_byte", tx_data, 8'h4B);
    wait_idle("wr_idle", 20);
    chk("wr_ack_log", pack_log(), 64'h4B);

    // read frame with stalling transmitter
    txlog.delete(); rdy_mode = 1; force_en = 1'b1; force_val = 32'hCAFEF00D;
    send(8'h52); send(8'h00); send(8'h10);
    chk("rd_strobe", fx_rd, 1'b1);
    chk("rd_addr", fx_raddr, 16'h0010);
    wait_idle("rd_idle", 80);
    chk("rd_log_len", txlog.size(), 5);
    chk("rd_log", pack_log(), 64'h52CAFEF00D);

    // bad command, then a normal write
    txlog.delete(); rdy_mode = 0;
    send(8'h33);
    chk("bad_ferr", frame_err, 1'b1);
    chk("bad_busy", busy, 1'b0);
    cyc();
    chk("bad_ferr_pulse", frame_err, 1'b0);
    send(8'h57); send(8'hAB); send(8'hCD); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    wait_idle("bad_wr_idle", 20);
    chk("bad_wr_addr", fx_waddr, 16'hABCD);
    chk("bad_wr_data", fx_data, 32'h01020304);
    chk("bad_wr_log", pack_log(), 64'h4B);

    // timeout, then a read
    txlog.delete();
    send(8'h57); send(8'h12);
    repeat (3) begin pluse_us = 1'b1; cyc(); end
    chk("to_still_busy", busy, 1'b1);
    chk("to_no_ferr", frame_err, 1'b0);
    pluse_us = 1'b1; cyc();
    chk("to_ferr", frame_err, 1'b1);
    chk("to_idle", busy, 1'b0);
    force_val = 32'h0BADF00D;
    send(8'h52); send(8'h00); send(8'h10);
    wait_idle("to_rd_idle", 30);
    chk("to_rd_log", pack_log(), 64'h520BADF00D);

    // overrun during TX, then reset mid-TX
    txlog.delete(); rdy_mode = 2; force_val = 32'h11223344;
    send(8'h52); send(8'h00); send(8'h20);
    v = 0;
    while (!tx_vld && v < 30) begin cyc(); v++; end
    chk("ovr_tx_vld", tx_vld, 1'b1);
    send(8'h57);
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_tx_hold", tx_data, 8'h52);
    cyc();
    chk("ovr_pulse_end", overrun, 1'b0);
    chk("ovr_busy", busy, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_tx_vld", tx_vld, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_raddr", fx_raddr, 16'h0);
    cyc();
    chk("mid_rst_no_rd", fx_rd, 1'b0);
    chk("mid_rst_nothing_sent", txlog.size(), 0);
    rdy_mode = 0; force_en = 1'b0;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 1499) == 0);
      rdy_mode = 1;
      if (rst) pend.delete();
      else if (m_mode == 2) begin
        if ($urandom_range(0, 19) == 0) begin rx_vld = 1'b1; rx_data = 8'($urandom); end
      end else if ($urandom_range(0, 1) == 1) begin
        if (pend.size() == 0) build_frame();
        v = pend.pop_front();
        if (v < 0) pluse_us = 1'b1;
        else begin rx_vld = 1'b1; rx_data = 8'(v); end
      end
      if ($urandom_range(0, 9) == 0) pluse_us = 1'b1;
      cyc();
    end
    rst = 1'b0; rdy_mode = 0;
    wait_idle("rand_idle", 100);

    // narrow-width instance: excess address/data bits dropped
    send2(8'h57); send2(8'hFF); send2(8'hFF); send2(8'hFF); send2(8'hFF);
    chk("w2_strobe", fx_wr2, 1'b1);
    chk("w2_addr", fx_waddr2, 10'h3FF);
    chk("w2_data", fx_data2, 12'hFFF);
    @(posedge clk_sys); #1;
    chk("w2_ack_vld", tx2_vld, 1'b1);
    chk("w2_ack", tx2_data, 8'h4B);
    @(posedge clk_sys); #1;
    chk("w2_idle", busy2, 1'b0);
    send2(8'h52); send2(8'h01); send2(8'h23);
    chk("r2_strobe", fx_rd2, 1'b1);
    chk("r2_addr", fx_raddr2, 10'h123);
    for (int i = 0; i < 20; i++) begin
      if (tx2_vld) got2.push_back(tx2_data);
      @(posedge clk_sys); #1;
    end
    chk("r2_len", got2.size(), 3);
    if (got2.size() == 3) chk("r2_bytes", {got2[0], got2[1], got2[2]}, 24'h520ABC);
    chk("r2_no_err", {ferr2, ovr2, busy2}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/commu_fx_bridge.md
Name: commu_fx_bridge

Overview:
Parametrised UART-byte-stream to fx-bus bridge. It generalises the fixed commu path with configurable address/data widths, a configurable read latency and an inter-byte timeout. It sits between the UART byte receiver/transmitter and the fx register bus in the commu subsystem. It parses command frames, issues single fx writes or reads, and returns acknowledge/read-data bytes.

Parameters:
ADDR_W, 16, fx address width in bits (1..32); ADDR_BYTES = ceil(ADDR_W/8)
DATA_W, 32, fx data width in bits (8..64); DATA_BYTES = ceil(DATA_W/8)
RD_LAT, 2, cycles from fx_rd pulse to valid fx_q (1..7)
TIMEOUT_US, 1000, max gap between bytes of one frame, in pluse_us ticks (1..65535)

Ports:
clk_sys  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
pluse_us  in  1  one-cycle tick every microsecond
rx_data  in  8  received UART byte
rx_vld  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to UART transmitter
tx_vld  out  1  tx_data valid; held until accepted
tx_rdy  in  1  transmitter accepts byte when tx_vld&tx_rdy
fx_waddr  out  ADDR_W  write address
fx_wr  out  1  one-cycle write strobe
fx_data  out  DATA_W  write data
fx_rd  out  1  one-cycle read strobe
fx_raddr  out  ADDR_W  read address
fx_q  in  DATA_W  read data, valid RD_LAT cycles after fx_rd
busy  out  1  high whenever state != IDLE
frame_err  out  1  one-cycle pulse: bad command byte or timeout
overrun  out  1  one-cycle pulse: rx byte dropped while not accepting

Behaviour:
- Reset (rst=1 at clk_sys edge): state IDLE. All outputs 0: tx_data, tx_vld, fx_*, busy, frame_err, overrun. Byte/timeout counters cleared. Reset mid-frame or mid-TX aborts immediately. No partial fx strobe after reset.
- Frame format: CMD byte, then ADDR_BYTES address bytes MSB-first. Write frames add DATA_BYTES data bytes MSB-first. CMD 0x57 = write, 0x52 = read. Any other CMD: frame_err pulse, stay IDLE.
- Width rule: bytes are shifted into registers of 8*BYTES bits; the low ADDR_W/DATA_W bits are used and upper excess bits are discarded.
- States:
  - IDLE: on rx_vld, decode CMD -> ADDR.
  - ADDR: collect address bytes; after the last -> DATA (write) or RD (read).
  - DATA: collect data bytes; after the last -> WR.
  - WR: fx_wr=1 for exactly one cycle, with fx_waddr/fx_data stable that cycle and held afterwards. Load ack byte 0x4B -> TX.
  - RD: fx_rd=1 for one cycle, fx_raddr held -> RDWAIT.
  - RDWAIT: count RD_LAT cycles, then capture fx_q. TX queue = 0x52 followed by DATA_BYTES data bytes, MSB-first -> TX.
  - TX: tx_vld=1 with the current byte. On tx_vld&tx_rdy, advance to the next byte in the next cycle (tx_vld stays high, no bubble). After the last byte is accepted, tx_vld=0 -> IDLE.
- Latency: the last write-data byte strobe at cycle N gives fx_wr at N+1 and tx_vld at N+2. The last read-address byte at N gives fx_rd at N+1, capture at N+1+RD_LAT, and tx_vld at N+2+RD_LAT.
- Timeout: in ADDR/DATA, the counter resets on each rx_vld and increments on pluse_us. When the counter reaches TIMEOUT_US: frame_err pulse, go to IDLE, discard the partial frame. The timeout is disabled in other states.
- rx_vld in WR/RD/RDWAIT/TX: byte dropped, overrun pulse, state unaffected.
- rx_vld and a timeout in the same cycle: the byte wins and the counter resets.
- busy=1 in every non-IDLE state, combinationally from state.

Test Plan:
- Write: send 57 12 34 DE AD BE EF -> fx_wr pulse 1 cycle after last byte, fx_waddr=0x1234, fx_data=0xDEADBEEF; tx sends 0x4B; busy returns 0.
- Read: send 52 00 10, fx_q=0xCAFEF00D driven at RD_LAT=2 -> fx_rd one cycle, fx_raddr=0x0010; tx sends 52 CA FE F0 0D in order; tx_rdy toggled randomly, no byte lost or duplicated.
- Bad command: send 0x33 -> frame_err pulse, no fx strobe, no tx; a following valid write frame completes normally.
- Timeout: send 57 12, then stall TIMEOUT_US=4 pluse_us ticks -> frame_err after 4th tick, IDLE; next 52 00 10 read works.
- Overrun/reset: during TX with tx_rdy=0, pulse rx_vld -> overrun pulse, tx bytes unchanged. Then assert rst for 1 cycle -> tx_vld=0, busy=0, all outputs 0.
- Width parametrisation: ADDR_W=10, DATA_W=12, send 57 FF FF FF FF -> fx_waddr=0x3FF, fx_data=0xFFF, ack 0x4B.
